// File: rtl/branch_predictor_table_if.sv
// Fetch/execute-facing bundle of the branch predictor table: prediction
// request/response plus the training path returned from execute.
interface branch_predictor_table_if #(
  parameter int PC_BITS    = 32,
  parameter int INDEX_BITS = 6
) ();
  logic                  request;
  logic [PC_BITS-1:0]    req_pc;
  logic                  prediction;
  logic                  pred_valid;
  logic [INDEX_BITS-1:0] pred_index;
  logic                  result;
  logic [INDEX_BITS-1:0] res_index;
  logic                  taken;

  modport master (
    output request, req_pc, result, res_index, taken,
    input  prediction, pred_valid, pred_index
  );

  modport slave (
    input  request, req_pc, result, res_index, taken,
    output prediction, pred_valid, pred_index
  );
endinterface

// File: rtl/branch_predictor_table.sv
// Table of saturating counters indexed by PC (optionally XORed with global
// history for gshare); predicts in one cycle, trained by resolved outcomes.
module branch_predictor_table #(
  parameter int PC_BITS    = 32,
  parameter int INDEX_BITS = 6,
  parameter int CTR_BITS   = 2,
  parameter int HIST_BITS  = 0,
  parameter int INIT_CTR   = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  branch_predictor_table_if.slave bus
);
  localparam int DEPTH  = 1 << INDEX_BITS;
  localparam int HIST_W = (HIST_BITS > 0) ? HIST_BITS : 1;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_ZERO = {CTR_BITS{1'b0}};
  localparam logic [CTR_BITS-1:0] CTR_ONE  = CTR_BITS'(1);
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(INIT_CTR);

  logic [CTR_BITS-1:0]   table_r [DEPTH];
  logic [HIST_W-1:0]     ghr_r;
  logic [HIST_W-1:0]     ghr_next_s;
  logic [INDEX_BITS-1:0] ghr_ext_s;
  logic [INDEX_BITS-1:0] idx_s;
  logic [INDEX_BITS-1:0] pred_index_r;
  logic                  prediction_r;
  logic                  pred_valid_r;
  logic                  unused_pc_bits_s;

  // Saturating step: never wraps past either end of the counter range.
  function automatic logic [CTR_BITS-1:0] ctr_next(input logic [CTR_BITS-1:0] ctr,
                                                   input logic dir);
    logic [CTR_BITS-1:0] nxt;
    if (dir && (ctr != CTR_MAX)) begin
      nxt = ctr + CTR_ONE;
    end else if (!dir && (ctr != CTR_ZERO)) begin
      nxt = ctr - CTR_ONE;
    end else begin
      nxt = ctr;
    end
    return nxt;
  endfunction

  // Index formation and next history value.
  always_comb begin
    ghr_ext_s = {INDEX_BITS{1'b0}};
    ghr_ext_s[HIST_W-1:0] = ghr_r;
    idx_s = bus.req_pc[INDEX_BITS+1:2] ^ ghr_ext_s;
    if (HIST_BITS == 0) begin
      ghr_next_s = {HIST_W{1'b0}};
    end else begin
      ghr_next_s = HIST_W'({ghr_r, bus.taken});
    end
  end

  // PC bits outside the index field never influence the prediction.
  assign unused_pc_bits_s = ^{bus.req_pc[PC_BITS-1:INDEX_BITS+2], bus.req_pc[1:0]};

  // Prediction pipeline register; reads the table before any same-edge update.
  always_ff @(posedge clk) begin
    if (reset) begin
      prediction_r <= 1'b0;
      pred_valid_r <= 1'b0;
      pred_index_r <= {INDEX_BITS{1'b0}};
    end else if (bus.request) begin
      prediction_r <= table_r[idx_s][CTR_BITS-1];
      pred_valid_r <= 1'b1;
      pred_index_r <= idx_s;
    end else begin
      pred_valid_r <= 1'b0;
    end
  end

  // Counter training and non-speculative history update.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        table_r[i] <= CTR_INIT;
      end
      ghr_r <= {HIST_W{1'b0}};
    end else if (bus.result) begin
      table_r[bus.res_index] <= ctr_next(table_r[bus.res_index], bus.taken);
      ghr_r <= ghr_next_s;
    end else begin
      ghr_r <= ghr_r;
    end
  end

  assign bus.prediction = prediction_r;
  assign bus.pred_valid = pred_valid_r;
  assign bus.pred_index = pred_index_r;
endmodule

// File: tb/tb_branch_predictor_table.sv
// Self-checking bench: three predictor configurations (2-bit bimodal, 3-bit
// bimodal, 4-bit-history gshare) checked against a reference table model.
module tb_branch_predictor_table;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  branch_predictor_table_if #(.PC_BITS(32), .INDEX_BITS(6)) a_if ();
  branch_predictor_table_if #(.PC_BITS(32), .INDEX_BITS(6)) c_if ();
  branch_predictor_table_if #(.PC_BITS(32), .INDEX_BITS(6)) g_if ();

  branch_predictor_table #(.CTR_BITS(2), .HIST_BITS(0)) u_bim2 (.clk(clk), .reset(reset), .bus(a_if));
  branch_predictor_table #(.CTR_BITS(3), .HIST_BITS(0)) u_bim3 (.clk(clk), .reset(reset), .bus(c_if));
  branch_predictor_table #(.CTR_BITS(2), .HIST_BITS(4)) u_gsh4 (.clk(clk), .reset(reset), .bus(g_if));

  logic        req [3];
  logic        res [3];
  logic        tk  [3];
  logic [31:0] pc  [3];
  logic [5:0]  ridx[3];
  logic        v_o [3];
  logic        p_o [3];
  logic [5:0]  i_o [3];

  assign a_if.request = req[0]; assign a_if.req_pc = pc[0];
  assign a_if.result  = res[0]; assign a_if.res_index = ridx[0]; assign a_if.taken = tk[0];
  assign c_if.request = req[1]; assign c_if.req_pc = pc[1];
  assign c_if.result  = res[1]; assign c_if.res_index = ridx[1]; assign c_if.taken = tk[1];
  assign g_if.request = req[2]; assign g_if.req_pc = pc[2];
  assign g_if.result  = res[2]; assign g_if.res_index = ridx[2]; assign g_if.taken = tk[2];
  assign v_o[0] = a_if.pred_valid; assign p_o[0] = a_if.prediction; assign i_o[0] = a_if.pred_index;
  assign v_o[1] = c_if.pred_valid; assign p_o[1] = c_if.prediction; assign i_o[1] = c_if.pred_index;
  assign v_o[2] = g_if.pred_valid; assign p_o[2] = g_if.prediction; assign i_o[2] = g_if.pred_index;

  // Reference model: counter table and history per configuration.
  int model [3][64];
  int ghr_m [3];
  int ctr_max [3] = '{3, 7, 3};
  int hist    [3] = '{0, 0, 4};
  string dn   [3] = '{"bim2", "bim3", "gsh4"};

  typedef struct {
    int         d;
    logic [5:0] idx;
    logic       pred;
  } exp_t;
  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_models();
    for (int d = 0; d < 3; d++) begin
      ghr_m[d] = 0;
      for (int i = 0; i < 64; i++) model[d][i] = 0;
    end
  endtask

  task automatic idle_all();
    for (int d = 0; d < 3; d++) begin
      req[d] = 1'b0; res[d] = 1'b0; tk[d] = 1'b0; pc[d] = 32'h0; ridx[d] = 6'h0;
    end
  endtask

  // One clock of stimulus on DUT d; a request pushes its expectation taken
  // from the model before that edge's training is applied.
  task automatic drive(input int d, input bit rq, input logic [31:0] p,
                       input bit rs, input logic [5:0] ri, input bit t);
    logic [5:0] ix;
    req[d] = rq; pc[d] = p; res[d] = rs; ridx[d] = ri; tk[d] = t;
    if (rq) begin
      ix = p[7:2] ^ 6'(ghr_m[d]);
      sb.push_back('{d: d, idx: ix, pred: (model[d][ix] > ctr_max[d] / 2)});
    end
    if (rs) begin
      if (t && model[d][ri] < ctr_max[d]) model[d][ri]++;
      else if (!t && model[d][ri] > 0) model[d][ri]--;
      ghr_m[d] = ((ghr_m[d] << 1) | int'(t)) & ((1 << hist[d]) - 1);
    end
    tick();
    req[d] = 1'b0; res[d] = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clear_models();
  endtask

  task automatic test_reset();
    do_reset();
    for (int d = 0; d < 3; d++) begin
      n_tests++;
      if (v_o[d] !== 1'b0 || p_o[d] !== 1'b0 || i_o[d] !== 6'h00) begin
        n_fail++;
        $display("FAIL reset %s: got v=%b p=%b idx=%h, want v=0 p=0 idx=00", dn[d], v_o[d], p_o[d], i_o[d]);
      end
    end
  endtask

  task automatic test_predict();
    exp_t e;
    drive(0, 1'b1, 32'h0000_0040, 1'b0, 6'h0, 1'b0);
    e = sb.pop_front();
    n_tests++;
    if (v_o[0] !== 1'b1 || p_o[0] !== 1'b0 || i_o[0] !== 6'h10 || e.idx !== 6'h10) begin
      n_fail++;
      $display("FAIL predict: got v=%b p=%b idx=%h, want v=1 p=0 idx=10", v_o[0], p_o[0], i_o[0]);
    end
    drive(0, 1'b0, 32'h0, 1'b0, 6'h0, 1'b0);
    n_tests++;
    if (v_o[0] !== 1'b0 || p_o[0] !== 1'b0 || i_o[0] !== 6'h10) begin
      n_fail++;
      $display("FAIL predict_hold: got v=%b p=%b idx=%h, want v=0 p=0 idx=10", v_o[0], p_o[0], i_o[0]);
    end
  endtask

  task automatic test_train();
    int   n_upd [3] = '{4, 1, 1};
    bit   dir   [3] = '{1'b1, 1'b0, 1'b0};
    logic want  [3] = '{1'b1, 1'b1, 1'b0};
    exp_t e;
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < n_upd[s]; k++) drive(0, 1'b0, 32'h0, 1'b1, 6'h10, dir[s]);
      drive(0, 1'b1, 32'h0000_0040, 1'b0, 6'h0, 1'b0);
      e = sb.pop_front();
      n_tests++;
      if (v_o[0] !== 1'b1 || p_o[0] !== e.pred || p_o[0] !== want[s] || i_o[0] !== e.idx) begin
        n_fail++;
        $display("FAIL train[%0d]: got v=%b p=%b idx=%h, want v=1 p=%b idx=%h", s, v_o[0], p_o[0], i_o[0], want[s], e.idx);
      end
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    // 2-bit entry 0x05: six decrements from 0 then one increment -> 1 (not taken)
    for (int k = 0; k < 6; k++) drive(0, 1'b0, 32'h0, 1'b1, 6'h05, 1'b0);
    drive(0, 1'b1, 32'h0000_0014, 1'b0, 6'h0, 1'b0);
    drive(0, 1'b0, 32'h0, 1'b1, 6'h05, 1'b1);
    drive(0, 1'b1, 32'h0000_0017, 1'b0, 6'h0, 1'b0);
    // 3-bit entry 0x07: nine increments saturate at 7, one decrement -> 6 (taken)
    for (int k = 0; k < 9; k++) drive(1, 1'b0, 32'h0, 1'b1, 6'h07, 1'b1);
    drive(1, 1'b1, 32'hFFFF_FF1C, 1'b0, 6'h0, 1'b0);
    drive(1, 1'b0, 32'h0, 1'b1, 6'h07, 1'b0);
    drive(1, 1'b1, 32'h0000_001D, 1'b0, 6'h0, 1'b0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_tests++;
      if (e.pred !== ((e.d == 1) ? 1'b1 : 1'b0)) begin
        n_fail++;
        $display("FAIL saturation_model %s: model pred=%b", dn[e.d], e.pred);
      end
    end
    n_tests++;
    if (model[0][5] != 1 || model[1][7] != 6 || p_o[1] !== 1'b1 || i_o[1] !== 6'h07) begin
      n_fail++;
      $display("FAIL saturation: got bim3 p=%b idx=%h, want p=1 idx=07", p_o[1], i_o[1]);
    end
  endtask

  // Per-DUT observation after each saturation request, checked separately.
  task automatic test_saturation_obs();
    exp_t e;
    logic want [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    int   dd   [4] = '{0, 0, 1, 1};
    logic [31:0] pp [4] = '{32'h14, 32'h17, 32'hFFFF_FF1C, 32'h1D};
    do_reset();
    for (int s = 0; s < 4; s++) begin
      if (s == 0) for (int k = 0; k < 6; k++) drive(0, 1'b0, 32'h0, 1'b1, 6'h05, 1'b0);
      if (s == 1) drive(0, 1'b0, 32'h0, 1'b1, 6'h05, 1'b1);
      if (s == 2) for (int k = 0; k < 9; k++) drive(1, 1'b0, 32'h0, 1'b1, 6'h07, 1'b1);
      if (s == 3) drive(1, 1'b0, 32'h0, 1'b1, 6'h07, 1'b0);
      drive(dd[s], 1'b1, pp[s], 1'b0, 6'h0, 1'b0);
      e = sb.pop_front();
      n_tests++;
      if (v_o[e.d] !== 1'b1 || p_o[e.d] !== e.pred || p_o[e.d] !== want[s] || i_o[e.d] !== e.idx) begin
        n_fail++;
        $display("FAIL saturation[%0d] %s: got v=%b p=%b idx=%h, want v=1 p=%b idx=%h", s, dn[e.d], v_o[e.d], p_o[e.d], i_o[e.d], want[s], e.idx);
      end
    end
  endtask

  task automatic test_collision();
    exp_t e;
    logic want [2] = '{1'b0, 1'b1};
    do_reset();
    drive(0, 1'b0, 32'h0, 1'b1, 6'h10, 1'b1);
    for (int s = 0; s < 2; s++) begin
      drive(0, 1'b1, 32'h0000_0040, (s == 0), 6'h10, 1'b1);
      e = sb.pop_front();
      n_tests++;
      if (v_o[0] !== 1'b1 || p_o[0] !== want[s] || p_o[0] !== e.pred || i_o[0] !== 6'h10) begin
        n_fail++;
        $display("FAIL collision[%0d]: got v=%b p=%b idx=%h, want v=1 p=%b idx=10", s, v_o[0], p_o[0], i_o[0], want[s]);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [31:0] p;
    for (int s = 0; s < 12; s++) begin
      p = (s < 4) ? 32'h0000_0040 : $urandom;
      drive(0, 1'b1, p, (s % 2 == 0), 6'($urandom_range(0, 63)) | ((s < 4) ? 6'h10 : 6'h00), 1'b1);
      e = sb.pop_front();
      n_tests++;
      if (v_o[0] !== 1'b1 || p_o[0] !== e.pred || i_o[0] !== e.idx) begin
        n_fail++;
        $display("FAIL back_to_back[%0d] pc=%h: got v=%b p=%b idx=%h, want v=1 p=%b idx=%h", s, p, v_o[0], p_o[0], i_o[0], e.pred, e.idx);
      end
    end
  endtask

  task automatic test_gshare();
    exp_t e;
    bit seq [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    do_reset();
    for (int k = 0; k < 4; k++) drive(2, 1'b0, 32'h0, 1'b1, 6'h00, seq[k]);
    drive(2, 1'b1, 32'h0000_0040, 1'b0, 6'h0, 1'b0);
    e = sb.pop_front();
    n_tests++;
    if (v_o[2] !== 1'b1 || i_o[2] !== 6'h1B || e.idx !== 6'h1B || p_o[2] !== e.pred) begin
      n_fail++;
      $display("FAIL gshare: got v=%b p=%b idx=%h, want v=1 p=%b idx=1b", v_o[2], p_o[2], i_o[2], e.pred);
    end
    do_reset();
    drive(2, 1'b1, 32'h0000_0040, 1'b0, 6'h0, 1'b0);
    e = sb.pop_front();
    n_tests++;
    if (v_o[2] !== 1'b1 || i_o[2] !== 6'h10 || p_o[2] !== 1'b0) begin
      n_fail++;
      $display("FAIL gshare_after_reset: got v=%b p=%b idx=%h, want v=1 p=0 idx=10", v_o[2], p_o[2], i_o[2]);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    for (int k = 0; k < 3; k++) drive(0, 1'b0, 32'h0, 1'b1, 6'h10, 1'b1);
    for (int k = 0; k < 3; k++) drive(2, 1'b0, 32'h0, 1'b1, 6'h00, 1'b1);
    drive(0, 1'b1, 32'h0000_0040, 1'b0, 6'h0, 1'b0);
    e = sb.pop_front();
    n_tests++;
    if (v_o[0] !== 1'b1 || p_o[0] !== 1'b1 || i_o[0] !== 6'h10) begin
      n_fail++;
      $display("FAIL reset_mid_pre: got v=%b p=%b idx=%h, want v=1 p=1 idx=10", v_o[0], p_o[0], i_o[0]);
    end
    req[0] = 1'b1; pc[0] = 32'h0000_0044; res[0] = 1'b1; ridx[0] = 6'h10; tk[0] = 1'b1;
    req[2] = 1'b1; pc[2] = 32'h0000_0040;
    do_reset();
    idle_all();
    for (int d = 0; d < 3; d += 2) begin
      n_tests++;
      if (v_o[d] !== 1'b0 || p_o[d] !== 1'b0 || i_o[d] !== 6'h00) begin
        n_fail++;
        $display("FAIL reset_mid %s: got v=%b p=%b idx=%h, want v=0 p=0 idx=00", dn[d], v_o[d], p_o[d], i_o[d]);
      end
    end
    for (int d = 0; d < 3; d += 2) begin
      drive(d, 1'b1, 32'h0000_0040, 1'b0, 6'h0, 1'b0);
      e = sb.pop_front();
      n_tests++;
      if (v_o[d] !== 1'b1 || p_o[d] !== 1'b0 || i_o[d] !== 6'h10) begin
        n_fail++;
        $display("FAIL reset_mid_post %s: got v=%b p=%b idx=%h, want v=1 p=0 idx=10", dn[d], v_o[d], p_o[d], i_o[d]);
      end
    end
  endtask

  initial begin
    idle_all();
    clear_models();
    tick();
    test_reset();
    test_predict();
    test_train();
    test_saturation();
    test_saturation_obs();
    test_collision();
    test_back_to_back();
    test_gshare();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/branch_predictor_table.md
Name: branch_predictor_table

Overview:
Parametrised successor to the single 2-bit saturating-counter predictor. Holds a table of 2^INDEX_BITS saturating counters of CTR_BITS width each. The table is indexed by PC bits, optionally XORed with a global history register (gshare mode). It sits beside the fetch stage, which issues requests, and is trained by the execute stage, which returns resolved outcomes together with the index the prediction used.

Parameters:
- PC_BITS, 32, width of req_pc.
- INDEX_BITS, 6, log2 of table depth (64 entries).
- CTR_BITS, 2, counter width; legal range 1..4.
- HIST_BITS, 0, global history length. 0 selects bimodal mode; 1..INDEX_BITS selects gshare mode.
- INIT_CTR, 0, reset value of every counter (0 = strongly not-taken); must be < 2^CTR_BITS.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- request  in  1  prediction request, sampled at posedge clk.
- req_pc  in  PC_BITS  PC of the branch being predicted.
- prediction  out  1  registered predicted direction (1 = taken).
- pred_valid  out  1  one-cycle pulse marking prediction/pred_index as fresh.
- pred_index  out  INDEX_BITS  table index used for the prediction; fetch carries it down the pipe.
- result  in  1  outcome valid, sampled at posedge clk.
- res_index  in  INDEX_BITS  index to train (the pred_index returned from the prediction).
- taken  in  1  resolved direction, qualified by result.

Behaviour:
- Reset (reset=1 at posedge), all in one cycle:
  - every counter <= INIT_CTR; ghr <= 0.
  - prediction <= 0, pred_valid <= 0, pred_index <= 0.
  - reset overrides request and result in that cycle; an in-flight prediction is dropped.
- Index function:
  - idx = req_pc[INDEX_BITS+1:2] (word-aligned PCs; PC bits 1:0 ignored).
  - gshare: idx = req_pc[INDEX_BITS+1:2] XOR zero_extend(ghr[HIST_BITS-1:0]).
- Predict, 1-cycle latency:
  - On a posedge with request=1: pred_index <= idx, prediction <= MSB of table[idx], pred_valid <= 1.
  - With request=0: pred_valid <= 0; prediction and pred_index hold their last values.
- Update:
  - On a posedge with result=1, table[res_index] is modified:
    - taken=1 and counter != 2^CTR_BITS-1: +1.
    - taken=0 and counter != 0: -1.
    - otherwise unchanged (saturates, never wraps).
  - gshare: ghr <= {ghr[HIST_BITS-2:0], taken} (HIST_BITS=1: ghr <= taken). History is updated non-speculatively, on result only.
  - bimodal: ghr is unused and holds 0.
- Simultaneous request and result in the same cycle:
  - Read-before-write: the prediction uses the counter and ghr values from before that edge, with no forwarding, including when idx == res_index.
  - The update still takes effect at that edge.
- Back-to-back requests are accepted every cycle; there is no stall or backpressure.
- Inputs are don't-care when their qualifier (request or result) is low.

Test Plan:
1. Reset, then request pc=0x0000_0040 (defaults) -> next cycle pred_valid=1, pred_index=0x10, prediction=0; the following cycle pred_valid=0.
2. Four results to index 0x10 with taken=1 (counter 0->1->2->3->3), then request pc=0x40 -> prediction=1. Then one taken=0 (counter 3->2) -> prediction still 1. Another taken=0 (counter 2->1) -> prediction 0.
3. Saturation: six taken=0 updates on an entry at 0 -> counter stays 0, no wrap. CTR_BITS=3: nine taken=1 updates -> counter 7; a single taken=0 leaves prediction=1.
4. Same-cycle collision: counter[0x10]=1, request pc=0x40 together with result index 0x10 taken=1 -> prediction=0 (old value). A request in the next cycle -> prediction=1.
5. gshare, HIST_BITS=4: results taken 1,0,1,1 (ghr=0b1011); request pc=0x40 -> pred_index=0x10^0x0B=0x1B. Repeat with reset between -> pred_index=0x10.
6. Reset asserted mid-operation with trained entries and request=1 in the same cycle -> pred_valid=0, prediction=0, all entries back to INIT_CTR, ghr=0 on the next request.
